ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising clk edge only.
REQ-004 rs1_data, rs2_data  input  32 each  register operands from decode.
REQ-005 immediate  input  32  sign-extended immediate from decode.
REQ-006 rd  input  5  destination register from decode.
REQ-007 regwrite_d, memwrite_d, jump_d, branch_d, alu_src_d  input  1 each  decode controls.
REQ-008 result_src_d  input  2  00 ALU, 01 memory, 10 pc+4.
REQ-009 alu_control_d  input  4 / branch_control_d  input  3  ALU op and branch condition.
REQ-010 pc, pc_plus_4  input  32 each  PC of the instruction and PC+4, from decode.
REQ-011 forward_a, forward_b  input  2 each  operand select: 00 register, 01 writeback_data, 10 alu_result_m, 11 register.
REQ-012 writeback_data  input  32  value being written back this cycle.
REQ-013 stall_e  input  1  hold EX/MEM register.
REQ-014 flush_e  input  1  load a bubble into EX/MEM register.
REQ-015 pc_src_e  output  1 / pc_target_e  output  32  combinational redirect request and target.
REQ-016 alu_result_m, write_data_m, pc_plus_4_m  output  32 each  registered.
REQ-017 rd_m  output  5; regwrite_m, memwrite_m  output  1; result_src_m  output  2; all registered.

Function
REQ-018 Operand A = mux(forward_a) over rs1_data/writeback_data/alu_result_m; operand B_fwd likewise with forward_b over rs2_data.
REQ-019 ALU second input = immediate when alu_src_d=1, else B_fwd.
REQ-020 alu_control_d: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed), 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 pass B (lui); others yield 0.
REQ-021 Shifts use B[4:0] only; add/sub wrap modulo 2^32; slt/sltu yield 32'h1 or 32'h0.
REQ-022 Branch condition compares A and B_fwd (never immediate): 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu; 010/011 never taken.
REQ-023 pc_target_e = pc + immediate, modulo 2^32.
REQ-024 pc_src_e = jump_d OR (branch_d AND condition); forced 0 while flush_e=1 or reset low.
REQ-025 Latency: ALU result visible on alu_result_m one cycle after operands present.
REQ-026 Normal cycle: register ALU result, B_fwd (write_data_m), rd, regwrite_d, memwrite_d, result_src_d, pc_plus_4.
REQ-027 stall_e=1, flush_e=0: all EX/MEM registers hold.
REQ-028 flush_e=1: regwrite_m=0, memwrite_m=0, result_src_m=00, rd_m=0, data registers 0; flush has priority over stall.
REQ-029 Forwarding source 10 uses current alu_result_m, so back-to-back dependents resolve with zero bubbles.
REQ-030 Writes with rd=0 pass through unchanged; suppression of x0 writes is the register file's job.

Reset
REQ-031 reset low at a rising edge: all registered outputs 0, overriding stall_e and flush_e.
REQ-032 pc_src_e 0 throughout reset; first post-reset cycle executes normally.
REQ-033 Reset mid-stall discards held state; no stall state persists after reset.

Verification
REQ-034 add: A=5, B=7, alu_control 0000, alu_src 0 -> next cycle alu_result_m=12, regwrite_m follows input.
REQ-035 Forwarding: forward_a=10 with alu_result_m=0x10, rs1_data=0 -> sub with B=1 gives 0xF; forward_b=01 with writeback_data=0xAA -> write_data_m=0xAA.
REQ-036 Branch: branch_d=1, code 100, A=0xFFFFFFFF, B=1 -> pc_src_e=1, pc_target_e=pc+imm; code 110 same operands -> pc_src_e=0.
REQ-037 Shift/boundary: sra A=0x80000000, B=33 -> 0xC0000000; add 0xFFFFFFFF+1 -> 0.
REQ-038 stall_e=1 two cycles then flush_e=1 with stall_e=1 -> outputs held, then regwrite_m=memwrite_m=0, rd_m=0.
REQ-039 reset low during stall with regwrite_m=1 -> all outputs 0 next edge, pc_src_e=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of a 5-stage RV32 pipeline: operand forwarding, ALU, branch resolution
// and the EX/MEM pipeline register.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] immediate,
    input  logic [4:0]  rd,
    input  logic        regwrite_d,
    input  logic        memwrite_d,
    input  logic        jump_d,
    input  logic        branch_d,
    input  logic        alu_src_d,
    input  logic [1:0]  result_src_d,
    input  logic [3:0]  alu_control_d,
    input  logic [2:0]  branch_control_d,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus_4,
    input  logic [1:0]  forward_a,
    input  logic [1:0]  forward_b,
    input  logic [31:0] writeback_data,
    input  logic        stall_e,
    input  logic        flush_e,
    output logic        pc_src_e,
    output logic [31:0] pc_target_e,
    output logic [31:0] alu_result_m,
    output logic [31:0] write_data_m,
    output logic [31:0] pc_plus_4_m,
    output logic [4:0]  rd_m,
    output logic        regwrite_m,
    output logic        memwrite_m,
    output logic [1:0]  result_src_m
);

    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] pc_plus_4_q, pc_plus_4_d;
    logic [4:0]  rd_q, rd_d;
    logic        regwrite_q, regwrite_d_nx;
    logic        memwrite_q, memwrite_d_nx;
    logic [1:0]  result_src_q, result_src_d_nx;

    logic [31:0] op_a;
    logic [31:0] b_fwd;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        branch_cond;

    // Source 10 reads our own registered result so back-to-back dependents need no bubble.
    always_comb begin
        case (forward_a)
            2'b01:   op_a = writeback_data;
            2'b10:   op_a = alu_result_q;
            default: op_a = rs1_data;
        endcase
        case (forward_b)
            2'b01:   b_fwd = writeback_data;
            2'b10:   b_fwd = alu_result_q;
            default: b_fwd = rs2_data;
        endcase
        alu_b = alu_src_d ? immediate : b_fwd;
    end

    always_comb begin
        case (alu_control_d)
            4'b0000: alu_out = op_a + alu_b;
            4'b0001: alu_out = op_a - alu_b;
            4'b0010: alu_out = op_a & alu_b;
            4'b0011: alu_out = op_a | alu_b;
            4'b0100: alu_out = op_a ^ alu_b;
            4'b0101: alu_out = {31'd0, $signed(op_a) < $signed(alu_b)};
            4'b0110: alu_out = {31'd0, op_a < alu_b};
            4'b0111: alu_out = op_a << alu_b[4:0];
            4'b1000: alu_out = op_a >> alu_b[4:0];
            4'b1001: alu_out = $unsigned($signed(op_a) >>> alu_b[4:0]);
            4'b1010: alu_out = alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    // Branches always compare the forwarded register operands, never the immediate.
    always_comb begin
        case (branch_control_d)
            3'b000:  branch_cond = (op_a == b_fwd);
            3'b001:  branch_cond = (op_a != b_fwd);
            3'b100:  branch_cond = ($signed(op_a) < $signed(b_fwd));
            3'b101:  branch_cond = ($signed(op_a) >= $signed(b_fwd));
            3'b110:  branch_cond = (op_a < b_fwd);
            3'b111:  branch_cond = (op_a >= b_fwd);
            default: branch_cond = 1'b0;
        endcase
    end

    assign pc_target_e = pc + immediate;
    assign pc_src_e    = reset && !flush_e && (jump_d || (branch_d && branch_cond));

    // Flush beats stall; stall simply keeps the current contents.
    always_comb begin
        alu_result_d    = alu_result_q;
        write_data_d    = write_data_q;
        pc_plus_4_d     = pc_plus_4_q;
        rd_d            = rd_q;
        regwrite_d_nx   = regwrite_q;
        memwrite_d_nx   = memwrite_q;
        result_src_d_nx = result_src_q;
        if (flush_e) begin
            alu_result_d    = 32'd0;
            write_data_d    = 32'd0;
            pc_plus_4_d     = 32'd0;
            rd_d            = 5'd0;
            regwrite_d_nx   = 1'b0;
            memwrite_d_nx   = 1'b0;
            result_src_d_nx = 2'b00;
        end else if (!stall_e) begin
            alu_result_d    = alu_out;
            write_data_d    = b_fwd;
            pc_plus_4_d     = pc_plus_4;
            rd_d            = rd;
            regwrite_d_nx   = regwrite_d;
            memwrite_d_nx   = memwrite_d;
            result_src_d_nx = result_src_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_result_q <= 32'd0;
            write_data_q <= 32'd0;
            pc_plus_4_q  <= 32'd0;
            rd_q         <= 5'd0;
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            result_src_q <= 2'b00;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus_4_q  <= pc_plus_4_d;
            rd_q         <= rd_d;
            regwrite_q   <= regwrite_d_nx;
            memwrite_q   <= memwrite_d_nx;
            result_src_q <= result_src_d_nx;
        end
    end

    assign alu_result_m = alu_result_q;
    assign write_data_m = write_data_q;
    assign pc_plus_4_m  = pc_plus_4_q;
    assign rd_m         = rd_q;
    assign regwrite_m   = regwrite_q;
    assign memwrite_m   = memwrite_q;
    assign result_src_m = result_src_q;

endmodule
